// File: rtl/seq_alu_muldiv.sv
// rtl/seq_alu_muldiv.sv - registered ALU with iterative mul/div and start/busy/done handshake
module seq_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             div_by_zero
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state;
    logic [SHW:0]     cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             is_muldiv;
    logic             is_signed;
    logic             div_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign shamt     = b[SHW-1:0];
    assign is_muldiv = (aluctrl[3:2] == 2'b10);
    assign is_signed = is_muldiv && !aluctrl[0];
    assign div_zero  = is_muldiv && aluctrl[1] && (b == '0);
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

    always_comb begin
        alu_res = '0;
        case (aluctrl)
            4'd0:    alu_res = a & b;
            4'd1:    alu_res = a | b;
            4'd2:    alu_res = a + b;
            4'd3:    alu_res = a ^ b;
            4'd4:    alu_res = a << shamt;
            4'd5:    alu_res = a >> shamt;
            4'd6:    alu_res = a - b;
            4'd7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd12:   alu_res = ~(a | b);
            4'd13:   alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd14:   alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand into the high half, then shift the pair right.
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    assign msum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_n = msum[WIDTH:1];
    assign mul_lo_n = {msum[0], acc_lo[WIDTH-1:1]};

    // Restoring step: remainder in acc_hi, dividend shifts out of acc_lo as quotient shifts in.
    logic [WIDTH:0]   dshift;
    logic             dge;
    logic [WIDTH-1:0] ddiff;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;
    assign dshift   = {acc_hi, acc_lo[WIDTH-1]};
    assign dge      = (dshift >= {1'b0, opnd});
    assign ddiff    = dshift[WIDTH-1:0] - opnd;
    assign div_hi_n = dge ? ddiff : dshift[WIDTH-1:0];
    assign div_lo_n = {acc_lo[WIDTH-2:0], dge};

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;
    assign prod   = {acc_hi, acc_lo};
    assign prod_f = neg_q ? -prod : prod;
    assign fin_hi = is_div ? (neg_r ? -acc_hi : acc_hi) : prod_f[2*WIDTH-1:WIDTH];
    assign fin_lo = is_div ? (neg_q ? -acc_lo : acc_lo) : prod_f[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            result      <= '0;
            hi          <= '0;
            lo          <= '0;
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_muldiv && !div_zero) begin
                            state  <= S_CALC;
                            cnt    <= (SHW+1)'(WIDTH);
                            is_div <= aluctrl[1];
                            neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r  <= is_signed && a[WIDTH-1];
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                        end else if (div_zero) begin
                            state       <= S_FINISH;
                            result      <= '1;
                            lo          <= '1;
                            hi          <= a;
                            zero        <= 1'b0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= S_FINISH;
                            result      <= alu_res;
                            zero        <= (alu_res == '0);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt != '0) begin
                        cnt    <= cnt - 1'b1;
                        acc_hi <= is_div ? div_hi_n : mul_hi_n;
                        acc_lo <= is_div ? div_lo_n : mul_lo_n;
                    end else begin
                        state       <= S_FINISH;
                        hi          <= fin_hi;
                        lo          <= fin_lo;
                        result      <= fin_lo;
                        zero        <= (fin_lo == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_FINISH);
endmodule

// File: tb/tb_seq_alu_muldiv.sv
// tb/tb_seq_alu_muldiv.sv - randomized and directed bench for seq_alu_muldiv at WIDTH 32 and 8
module tb_seq_alu_muldiv;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, zero, dbz;
    logic [3:0]  aluctrl;
    logic [31:0] a, b, result, hi, lo;
    logic        rst8, start8, busy8, done8, zero8, dbz8;
    logic [3:0]  aluctrl8;
    logic [7:0]  a8, b8, result8, hi8, lo8;

    int tests = 0;
    int fails = 0;
    logic [63:0] m_hi, m_lo, m_hi8, m_lo8;

    always #5 clk = ~clk;

    seq_alu_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .aluctrl(aluctrl), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo),
        .zero(zero), .div_by_zero(dbz)
    );

    seq_alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .aluctrl(aluctrl8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .hi(hi8), .lo(lo8),
        .zero(zero8), .div_by_zero(dbz8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values held in 64-bit containers.
    task automatic model(input int w, input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv,
                         inout logic [63:0] mhi, inout logic [63:0] mlo,
                         output logic [63:0] res, output logic edbz, output int lat);
        logic [63:0] mask, p;
        longint sa, sb, q, r;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(av);
        sb = longint'(bv);
        if (av[w-1]) sa = sa - (longint'(1) << w);
        if (bv[w-1]) sb = sb - (longint'(1) << w);
        sh = int'(bv) & (w - 1);
        res = 0; edbz = 1'b0; lat = 0;
        case (op)
            4'd0:  res = av & bv;
            4'd1:  res = av | bv;
            4'd2:  res = (av + bv) & mask;
            4'd3:  res = av ^ bv;
            4'd4:  res = (av << sh) & mask;
            4'd5:  res = av >> sh;
            4'd6:  res = (av - bv) & mask;
            4'd7:  res = (sa < sb) ? 64'd1 : 64'd0;
            4'd8, 4'd9: begin
                p = (op == 4'd8) ? 64'(sa * sb) : av * bv;
                mhi = (p >> w) & mask;
                mlo = p & mask;
                res = mlo;
                lat = w + 1;
            end
            4'd10, 4'd11: begin
                if (bv == 0) begin
                    mlo = mask; mhi = av; res = mask; edbz = 1'b1;
                end else begin
                    if (op == 4'd10) begin
                        q = sa / sb; r = sa % sb;
                        mlo = 64'(q) & mask; mhi = 64'(r) & mask;
                    end else begin
                        mlo = av / bv; mhi = av % bv;
                    end
                    res = mlo;
                    lat = w + 1;
                end
            end
            4'd12: res = ~(av | bv) & mask;
            4'd13: res = (av < bv) ? 64'd1 : 64'd0;
            4'd14: res = 64'(sa >>> sh) & mask;
            default: res = 0;
        endcase
    endtask

    task automatic run32(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input bit poke);
        logic [63:0] eres;
        logic edbz;
        int elat, n;
        model(32, op, av, bv, m_hi, m_lo, eres, edbz, elat);
        start = 1'b1; aluctrl = op; a = av; b = bv;
        @(posedge clk); #1;
        start = poke; aluctrl = 4'd2; a = $urandom; b = $urandom;
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        start = 1'b0;
        chk($sformatf("latency op%0d", op), n, elat);
        chk($sformatf("result op%0d", op), result, eres);
        chk($sformatf("hi op%0d", op), hi, m_hi);
        chk($sformatf("lo op%0d", op), lo, m_lo);
        chk($sformatf("zero op%0d", op), zero, (eres == 0));
        chk($sformatf("dbz op%0d", op), dbz, edbz);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_back_idle", busy, 0);
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
        logic [63:0] eres;
        logic edbz;
        int elat, n;
        model(8, op, av, bv, m_hi8, m_lo8, eres, edbz, elat);
        start8 = 1'b1; aluctrl8 = op; a8 = av; b8 = bv;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (!done8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("w8 latency op%0d", op), n, elat);
        chk($sformatf("w8 result op%0d", op), result8, eres);
        chk($sformatf("w8 hi op%0d", op), hi8, m_hi8);
        chk($sformatf("w8 lo op%0d", op), lo8, m_lo8);
        chk($sformatf("w8 dbz op%0d", op), dbz8, edbz);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; aluctrl = 4'd0; a = '0; b = '0;
        rst8 = 1'b1; start8 = 1'b0; aluctrl8 = 4'd0; a8 = '0; b8 = '0;
        m_hi = 0; m_lo = 0; m_hi8 = 0; m_lo8 = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; rst8 = 1'b0;

        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset zero", zero, 1);
        chk("reset dbz", dbz, 0);

        run32(4'd2, 32'd7, 32'd3, 1'b0);
        chk("add const", result, 32'd10);
        run32(4'd6, 32'd10, 32'd10, 1'b0);
        chk("sub zero const", zero, 1);
        run32(4'd7, 32'hFFFFFFFF, 32'd1, 1'b0);
        run32(4'd13, 32'hFFFFFFFF, 32'd1, 1'b0);
        run32(4'd14, 32'h80000000, 32'd4, 1'b0);
        chk("sra const", result, 32'hF8000000);
        run32(4'd8, 32'hFFFFFFFD, 32'd5, 1'b0);
        chk("mult hi const", hi, 32'hFFFFFFFF);
        chk("mult lo const", lo, 32'hFFFFFFF1);
        run32(4'd9, 32'hFFFFFFFF, 32'd2, 1'b1);
        chk("multu hi const", hi, 32'd1);
        run32(4'd11, 32'd200, 32'd7, 1'b0);
        chk("divu lo const", lo, 32'd28);
        run32(4'd10, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div hi const", hi, 32'hFFFFFFFF);
        run32(4'd10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div min lo const", lo, 32'h80000000);
        run32(4'd11, 32'd5, 32'd0, 1'b0);
        chk("divz hi const", hi, 32'd5);
        run32(4'd2, 32'd1, 32'd2, 1'b0);
        run32(4'd15, 32'd9, 32'd9, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ((rop == 4'd10 || rop == 4'd11) && $urandom_range(0, 3) == 0) rb = 0;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            run32(rop, ra, rb, $urandom_range(0, 1) == 1);
        end

        // Abort a MULT mid-calculation; a start pulsed during CALC must be ignored.
        start = 1'b1; aluctrl = 4'd8; a = 32'hFFFFFFFD; b = 32'd5;
        @(posedge clk); #1;
        aluctrl = 4'd2; a = 32'd7; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("abort no early done", done, 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 0; m_lo = 0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort result", result, 0);
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        chk("abort zero", zero, 1);
        chk("abort dbz", dbz, 0);
        @(posedge clk); #1;
        chk("abort no late done", done, 0);
        run32(4'd2, 32'd7, 32'd3, 1'b0);

        start8 = 1'b1; aluctrl8 = 4'd9; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        aluctrl8 = 4'd2;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        chk("w8 abort busy", busy8, 0);
        chk("w8 abort done", done8, 0);
        chk("w8 abort hi", hi8, 0);
        chk("w8 abort lo", lo8, 0);
        chk("w8 abort zero", zero8, 1);
        run8(4'd9, 8'hFF, 8'hFF);
        chk("w8 multu hi const", hi8, 8'hFE);
        chk("w8 multu lo const", lo8, 8'h01);
        run8(4'd10, 8'h80, 8'hFF);
        run8(4'd8, 8'h85, 8'h13);
        run8(4'd14, 8'h90, 8'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
